// File: rtl/pc_redirect_ctrl.sv
// Program counter owner: arbitrates branch / jump-register / jump redirects,
// holds under stall, buffers a redirect seen while stalled, and pulses flush.
module pc_redirect_ctrl #(
   parameter int              PC_W     = 12,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            jr,
   input  logic [PC_W-1:0] jr_target,
   input  logic            jump,
   input  logic [PC_W-1:0] j_target,
   output logic [PC_W-1:0] pc,
   output logic [1:0]      pc_sel,
   output logic            flush,
   output logic            pending
);

   localparam logic [1:0] SEL_SEQ = 2'b00;
   localparam logic [1:0] SEL_BR  = 2'b01;
   localparam logic [1:0] SEL_JMP = 2'b10;
   localparam logic [1:0] SEL_JR  = 2'b11;

   typedef enum logic {RUN, HOLD} state_t;

   state_t          state, state_nx;
   logic [PC_W-1:0] pc_nx;
   logic [1:0]      pc_sel_nx;
   logic            flush_nx;
   logic [PC_W-1:0] pend_tgt, pend_tgt_nx;
   logic [1:0]      pend_src, pend_src_nx;

   logic            cur_any;
   logic [1:0]      cur_src;
   logic [PC_W-1:0] cur_tgt;

   // Select codes are not ordered by priority, so compare through a rank.
   function automatic logic [1:0] rank_of(input logic [1:0] sel);
      case (sel)
         SEL_BR:  rank_of = 2'd3;
         SEL_JR:  rank_of = 2'd2;
         SEL_JMP: rank_of = 2'd1;
         default: rank_of = 2'd0;
      endcase
   endfunction

   always_comb begin
      cur_any = br_taken | jr | jump;
      cur_src = SEL_SEQ;
      cur_tgt = pc + PC_W'(1);
      if (br_taken) begin
         cur_src = SEL_BR;
         cur_tgt = br_target;
      end else if (jr) begin
         cur_src = SEL_JR;
         cur_tgt = jr_target;
      end else if (jump) begin
         cur_src = SEL_JMP;
         cur_tgt = j_target;
      end
   end

   // NOTE: every variable gets a default before the case so no path can
   // leave one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx    = state;
      pc_nx       = pc;
      pc_sel_nx   = pc_sel;
      flush_nx    = 1'b0;
      pend_tgt_nx = pend_tgt;
      pend_src_nx = pend_src;
      case (state)
         RUN: begin
            if (!stall) begin
               pc_nx     = cur_tgt;
               pc_sel_nx = cur_src;
               flush_nx  = cur_any;
            end else if (cur_any) begin
               pend_tgt_nx = cur_tgt;
               pend_src_nx = cur_src;
               state_nx    = HOLD;
            end
         end
         HOLD: begin
            if (stall) begin
               if (cur_any && rank_of(cur_src) > rank_of(pend_src)) begin
                  pend_tgt_nx = cur_tgt;
                  pend_src_nx = cur_src;
               end
            end else begin
               // Ties go to the fresher current-cycle target.
               if (cur_any && rank_of(cur_src) >= rank_of(pend_src)) begin
                  pc_nx     = cur_tgt;
                  pc_sel_nx = cur_src;
               end else begin
                  pc_nx     = pend_tgt;
                  pc_sel_nx = pend_src;
               end
               flush_nx    = 1'b1;
               pend_tgt_nx = '0;
               pend_src_nx = SEL_SEQ;
               state_nx    = RUN;
            end
         end
         default: state_nx = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= RUN;
      else          state <= state_nx;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc       <= RESET_PC;
         pc_sel   <= SEL_SEQ;
         flush    <= 1'b0;
         pend_tgt <= '0;
         pend_src <= SEL_SEQ;
      end else begin
         pc       <= pc_nx;
         pc_sel   <= pc_sel_nx;
         flush    <= flush_nx;
         pend_tgt <= pend_tgt_nx;
         pend_src <= pend_src_nx;
      end
   end

   assign pending = (state == HOLD);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a rank-based model.
module tb_pc_redirect_ctrl;

   localparam int PC_W = 12;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic            stall = 1'b0;
   logic            br_taken = 1'b0;
   logic [PC_W-1:0] br_target = '0;
   logic            jr = 1'b0;
   logic [PC_W-1:0] jr_target = '0;
   logic            jump = 1'b0;
   logic [PC_W-1:0] j_target = '0;
   logic [PC_W-1:0] pc;
   logic [1:0]      pc_sel;
   logic            flush;
   logic            pending;

   int checks = 0;
   int errors = 0;

   pc_redirect_ctrl #(.PC_W(PC_W), .RESET_PC(12'h000)) dut (
      .clock(clock), .reset_n(reset_n), .stall(stall),
      .br_taken(br_taken), .br_target(br_target),
      .jr(jr), .jr_target(jr_target),
      .jump(jump), .j_target(j_target),
      .pc(pc), .pc_sel(pc_sel), .flush(flush), .pending(pending)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // Model: sources ranked 3=branch 2=jr 1=jump 0=none, target bookkeeping in ints.
   int        m_pc, m_sel, m_flush, m_hold, m_prank, m_ptgt;
   int        sel_of_rank [4] = '{0, 2, 3, 1};

   always @(posedge clock or negedge reset_n) begin
      int rank, tgt;
      if (!reset_n) begin
         m_pc = 0; m_sel = 0; m_flush = 0; m_hold = 0; m_prank = 0; m_ptgt = 0;
      end else begin
         rank = br_taken ? 3 : jr ? 2 : jump ? 1 : 0;
         tgt  = br_taken ? int'(br_target) : jr ? int'(jr_target) : jump ? int'(j_target) : 0;
         if (stall) begin
            m_flush = 0;
            if (rank > m_prank) begin
               m_prank = rank; m_ptgt = tgt; m_hold = 1;
            end
         end else if (rank == 0 && m_prank == 0) begin
            m_pc = (m_pc + 1) % 4096; m_sel = 0; m_flush = 0;
         end else begin
            if (rank >= m_prank) begin m_pc = tgt; m_sel = sel_of_rank[rank]; end
            else                 begin m_pc = m_ptgt; m_sel = sel_of_rank[m_prank]; end
            m_flush = 1; m_hold = 0; m_prank = 0; m_ptgt = 0;
         end
      end
   end

   always @(negedge clock) begin
      check("pc", 32'(pc), 32'(m_pc));
      check("pc_sel", 32'(pc_sel), 32'(m_sel));
      check("flush", 32'(flush), 32'(m_flush));
      check("pending", 32'(pending), 32'(m_hold));
   end

   // Drive one cycle of inputs at a negedge and return at the next negedge.
   task automatic step(input logic s, input logic b, input int bt,
                       input logic r, input int rt, input logic j, input int jt);
      stall = s; br_taken = b; br_target = PC_W'(bt);
      jr = r; jr_target = PC_W'(rt); jump = j; j_target = PC_W'(jt);
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic mid_reset();
      #2 reset_n = 1'b0;
      #1;
      check("async_reset_pc", 32'(pc), 32'h0);
      check("async_reset_pending", 32'(pending), 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      @(negedge clock);
      @(negedge clock);
      check("reset_pc", 32'(pc), 32'h0);
      check("reset_flush", 32'(flush), 32'h0);
      reset_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         idle(1);
         check("free_run_pc", 32'(pc), 32'(i));
      end
      mid_reset();

      step(0, 0, 0, 0, 0, 1, 12'hFFE);
      check("jump_ffe", 32'(pc), 32'hFFE);
      check("jump_flush", 32'(flush), 32'h1);
      idle(1); check("wrap_fff", 32'(pc), 32'hFFF); check("wrap_noflush", 32'(flush), 32'h0);
      idle(1); check("wrap_000", 32'(pc), 32'h000);
      idle(1); check("wrap_001", 32'(pc), 32'h001);

      step(0, 0, 0, 0, 0, 1, 10);
      step(0, 1, 80, 0, 0, 1, 40);
      check("br_beats_jump_pc", 32'(pc), 32'd80);
      check("br_beats_jump_sel", 32'(pc_sel), 32'b01);
      check("br_flush", 32'(flush), 32'h1);
      idle(1);
      check("after_br_pc", 32'(pc), 32'd81);
      check("flush_one_cycle", 32'(flush), 32'h0);

      step(0, 0, 0, 0, 0, 1, 20);
      step(1, 0, 0, 0, 0, 1, 50);
      check("stall_hold_pc", 32'(pc), 32'd20);
      check("stall_pending", 32'(pending), 32'h1);
      step(1, 1, 90, 0, 0, 0, 0);
      check("stall_hold_pc2", 32'(pc), 32'd20);
      step(0, 0, 0, 0, 0, 0, 0);
      check("release_pc", 32'(pc), 32'd90);
      check("release_sel", 32'(pc_sel), 32'b01);
      check("release_flush", 32'(flush), 32'h1);
      check("release_pending", 32'(pending), 32'h0);

      step(1, 0, 0, 1, 100, 0, 0);
      step(0, 0, 0, 0, 0, 1, 200);
      check("jr_pending_wins_pc", 32'(pc), 32'd100);
      check("jr_pending_wins_sel", 32'(pc_sel), 32'b11);

      step(1, 0, 0, 0, 0, 1, 30);
      check("hold_before_reset", 32'(pending), 32'h1);
      stall = 1'b0; jump = 1'b0;
      mid_reset();
      check("post_reset_pc", 32'(pc), 32'h0);
      idle(1);
      check("post_reset_inc", 32'(pc), 32'h1);
      check("post_reset_noflush", 32'(flush), 32'h0);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) < 4,
              $urandom_range(0, 9) < 2, $urandom_range(0, 4095),
              $urandom_range(0, 9) < 2, $urandom_range(0, 4095),
              $urandom_range(0, 9) < 2, $urandom_range(0, 4095));
      end
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
